mem_fill_responder: RTL and testbench

- Memory-side responder for the I-cache and D-cache fill FSMs. Sits between the cache fill logic and the 4-cycle pipelined multicycle memory.
- Arbitrates three request sources: D-cache write-through, D-cache block fill and I-cache block fill.
- For a fill, issues the 8 word addresses of one 16-byte block, one per cycle, and streams the returned words back to the requester with a word index.

---
 rtl/cache_pkg.sv | 11 +
 rtl/mem_fill_responder_if.sv | 36 +++
 rtl/fill_counter.sv | 21 ++
 rtl/mem_fill_responder.sv | 85 ++++++++
 tb/tb_mem_fill_responder.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding, block geometry and address helper for the fill responder.
package cache_pkg;
    localparam int MEM_LATENCY = 4;
    localparam int WORDS_PER_BLOCK = 8;
    localparam logic [15:0] BLOCK_MASK = 16'hFFF0;
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL_D, S_FILL_I} state_t;
    // Low nibble of base is zero, so the sum stays inside the 16-byte block.
    function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [2:0] idx);
        return base + {12'd0, idx, 1'b0};
    endfunction
endpackage

// File: rtl/mem_fill_responder_if.sv
// mem_fill_responder_if: cache request/response and memory bus signals of the fill responder.
interface mem_fill_responder_if;
    logic        i_fill_req;
    logic [15:0] i_fill_addr;
    logic        d_fill_req;
    logic [15:0] d_fill_addr;
    logic        d_wr_req;
    logic [15:0] d_wr_addr;
    logic [15:0] d_wr_data;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] fill_data;
    logic [2:0]  fill_word_idx;
    logic        i_fill_valid;
    logic        d_fill_valid;
    logic        i_fill_done;
    logic        d_fill_done;
    logic        d_wr_ack;
    logic        busy;
    modport slave (
        input  i_fill_req, i_fill_addr, d_fill_req, d_fill_addr, d_wr_req, d_wr_addr, d_wr_data,
               mem_data_out, mem_data_valid,
        output mem_addr, mem_data_in, mem_enable, mem_wr, fill_data, fill_word_idx,
               i_fill_valid, d_fill_valid, i_fill_done, d_fill_done, d_wr_ack, busy
    );
    modport master (
        output i_fill_req, i_fill_addr, d_fill_req, d_fill_addr, d_wr_req, d_wr_addr, d_wr_data,
               mem_data_out, mem_data_valid,
        input  mem_addr, mem_data_in, mem_enable, mem_wr, fill_data, fill_word_idx,
               i_fill_valid, d_fill_valid, i_fill_done, d_fill_done, d_wr_ack, busy
    );
endinterface

// File: rtl/fill_counter.sv
// fill_counter: 3-bit block word counter; done sticks once all words of the block have been counted.
module fill_counter
    import cache_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [2:0] count,
    output logic       done
);
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
            done  <= 1'b0;
        end else if (en && !done) begin
            count <= count + 3'd1;
            done  <= count == 3'(WORDS_PER_BLOCK - 1);
        end
    end
endmodule

// File: rtl/mem_fill_responder.sv
// mem_fill_responder: arbitrates D write-through, D fill and I fill onto the pipelined memory
// and streams the returned block words back to the owning cache.
module mem_fill_responder
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    mem_fill_responder_if.slave   bus
);
    state_t      state, state_d;
    logic [15:0] base, wr_addr, wr_data, rx_data;
    logic        rx_valid;
    logic [2:0]  issue_cnt, recv_cnt;
    logic        issue_done, recv_done;
    logic        in_fill, issuing, last_word, accept;

    assign in_fill   = state == S_FILL_D || state == S_FILL_I;
    assign issuing   = in_fill && !issue_done;
    assign last_word = rx_valid && recv_cnt == 3'(WORDS_PER_BLOCK - 1);
    // Words before the first issue or beyond the eighth are protocol errors and are dropped.
    assign accept    = in_fill && bus.mem_data_valid && (issue_cnt != 3'd0 || issue_done)
                       && !recv_done && !last_word;

    fill_counter u_issue (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == S_IDLE),
        .en    (issuing),
        .count (issue_cnt),
        .done  (issue_done)
    );

    fill_counter u_recv (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == S_IDLE),
        .en    (rx_valid),
        .count (recv_cnt),
        .done  (recv_done)
    );

    always_ff @(posedge clk) begin
        state <= !rst_n ? S_IDLE : state_d;
    end

    always_comb begin
        state_d = state;
        bus.mem_enable    = state == S_WRITE || issuing;
        bus.mem_wr        = state == S_WRITE;
        bus.mem_addr      = state == S_WRITE ? wr_addr : issuing ? word_addr(base, issue_cnt) : '0;
        bus.mem_data_in   = state == S_WRITE ? wr_data : '0;
        bus.fill_data     = rx_valid ? rx_data : '0;
        bus.fill_word_idx = rx_valid ? recv_cnt : '0;
        bus.i_fill_valid  = rx_valid && state == S_FILL_I;
        bus.d_fill_valid  = rx_valid && state == S_FILL_D;
        bus.i_fill_done   = last_word && state == S_FILL_I;
        bus.d_fill_done   = last_word && state == S_FILL_D;
        bus.d_wr_ack      = state == S_WRITE;
        bus.busy          = state != S_IDLE;
        case (state)
            S_IDLE:  state_d = bus.d_wr_req ? S_WRITE : bus.d_fill_req ? S_FILL_D
                             : bus.i_fill_req ? S_FILL_I : S_IDLE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = last_word ? S_IDLE : state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base     <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= accept;
            if (accept) rx_data <= bus.mem_data_out;
            if (state == S_IDLE) begin
                base    <= (bus.d_fill_req ? bus.d_fill_addr : bus.i_fill_addr) & BLOCK_MASK;
                wr_addr <= bus.d_wr_addr;
                wr_data <= bus.d_wr_data;
            end
        end
    end
endmodule

// File: tb/tb_mem_fill_responder.sv
// tb_mem_fill_responder: directed scenarios against a 4-cycle memory model returning addr^0xA5A5.
module tb_mem_fill_responder;
    import cache_pkg::*;

    typedef struct packed {logic [31:0] c; logic wr; logic [15:0] a; logic [15:0] d;} acc_t;
    typedef struct packed {logic [31:0] c; logic iv; logic dv; logic id; logic dd; logic [2:0] idx; logic [15:0] d;} out_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inj = 1'b0;
    int cyc = 0, checks = 0, failures = 0, bad_idle = 0, late_v = 0;
    acc_t acc_q[$];
    out_t out_q[$];
    int ack_q[$];

    mem_fill_responder_if bus();
    mem_fill_responder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic rv = 1'b0;
    logic [15:0] ra = '0;
    logic [MEM_LATENCY-1:0] pv = '0;
    logic [15:0] pa [MEM_LATENCY];
    always @(negedge clk) begin
        rv <= bus.mem_enable & ~bus.mem_wr;
        ra <= bus.mem_addr;
    end
    always @(posedge clk) begin
        pv <= {pv[MEM_LATENCY-2:0], rv};
        pa[0] <= ra;
        for (int i = 1; i < MEM_LATENCY; i++) pa[i] <= pa[i-1];
    end
    assign bus.mem_data_valid = pv[MEM_LATENCY-1] | inj;
    assign bus.mem_data_out   = pv[MEM_LATENCY-1] ? pa[MEM_LATENCY-1] ^ 16'hA5A5 : 16'hDEAD;

    always @(negedge clk) begin
        if (bus.mem_enable) acc_q.push_back({cyc, bus.mem_wr, bus.mem_addr, bus.mem_data_in});
        if (bus.i_fill_valid | bus.d_fill_valid | bus.i_fill_done | bus.d_fill_done)
            out_q.push_back({cyc, bus.i_fill_valid, bus.d_fill_valid, bus.i_fill_done, bus.d_fill_done,
                             bus.fill_word_idx, bus.fill_data});
        if (bus.d_wr_ack) ack_q.push_back(cyc);
        if (!bus.mem_enable && (bus.mem_addr != 0 || bus.mem_data_in != 0 || bus.mem_wr)) bad_idle++;
        if (!(bus.i_fill_valid | bus.d_fill_valid) && (bus.fill_data != 0 || bus.fill_word_idx != 0)) bad_idle++;
        if (bus.mem_data_valid && !bus.busy) late_v++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input bit i_side, input int max, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max && !ok; k++) begin
            @(negedge clk);
            ok = i_side ? bus.i_fill_done : bus.d_fill_done;
        end
    endtask

    task automatic test_reset();
        logic [57:0] o;
        bus.i_fill_req = 0; bus.d_fill_req = 0; bus.d_wr_req = 0;
        bus.i_fill_addr = '0; bus.d_fill_addr = '0; bus.d_wr_addr = '0; bus.d_wr_data = '0;
        rst_n = 0;
        tick(2);
        o = {bus.mem_addr, bus.mem_data_in, bus.mem_enable, bus.mem_wr, bus.fill_data, bus.fill_word_idx,
             bus.i_fill_valid, bus.d_fill_valid, bus.i_fill_done, bus.d_fill_done, bus.d_wr_ack};
        checks++;
        if (o !== '0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", o); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        rst_n = 1;
        tick(2);
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_i_fill();
        int c0; bit ok; acc_t ea; out_t eo;
        acc_q.delete(); out_q.delete();
        c0 = cyc;
        bus.i_fill_addr = 16'h0046; bus.i_fill_req = 1;
        wait_done(1, 40, ok);
        bus.i_fill_req = 0;
        checks++;
        if (!ok) begin failures++; $display("FAIL i_fill_done: got timeout expected pulse"); end
        tick(2);
        checks++;
        if (acc_q.size() != 8) begin failures++; $display("FAIL i_fill_naddr: got %0d expected 8", acc_q.size()); end
        checks++;
        if (out_q.size() != 8) begin failures++; $display("FAIL i_fill_nword: got %0d expected 8", out_q.size()); end
        for (int k = 0; k < 8 && k < acc_q.size(); k++) begin
            ea = {32'(c0 + 1 + k), 1'b0, 16'(16'h0040 + 2 * k), 16'h0};
            checks++;
            if (acc_q[k] !== ea) begin failures++; $display("FAIL i_fill_addr%0d: got %h expected %h", k, acc_q[k], ea); end
        end
        for (int k = 0; k < 8 && k < out_q.size(); k++) begin
            eo = {32'(c0 + 6 + k), 1'b1, 1'b0, k == 7, 1'b0, 3'(k), 16'(16'h0040 + 2 * k) ^ 16'hA5A5};
            checks++;
            if (out_q[k] !== eo) begin failures++; $display("FAIL i_fill_word%0d: got %h expected %h", k, out_q[k], eo); end
        end
    endtask

    task automatic test_priority();
        int c0; acc_t ea; out_t eo;
        acc_q.delete(); out_q.delete(); ack_q.delete();
        bus.d_wr_addr = 16'h1000; bus.d_wr_data = 16'hBEEF;
        bus.d_fill_addr = 16'h2008; bus.i_fill_addr = 16'h0010;
        bus.d_wr_req = 1; bus.d_fill_req = 1; bus.i_fill_req = 1;
        c0 = cyc;
        for (int k = 0; k < 80 && (bus.d_wr_req || bus.d_fill_req || bus.i_fill_req); k++) begin
            @(negedge clk);
            if (bus.d_wr_ack) bus.d_wr_req = 0;
            if (bus.d_fill_done) bus.d_fill_req = 0;
            if (bus.i_fill_done) bus.i_fill_req = 0;
        end
        checks++;
        if (bus.d_wr_req || bus.d_fill_req || bus.i_fill_req) begin
            failures++;
            $display("FAIL prio_complete: got pending %b%b%b expected 000", bus.d_wr_req, bus.d_fill_req, bus.i_fill_req);
            bus.d_wr_req = 0; bus.d_fill_req = 0; bus.i_fill_req = 0;
        end
        tick(2);
        checks++;
        if (ack_q.size() != 1 || ack_q[0] != c0 + 1) begin
            failures++; $display("FAIL prio_ack: got %0d acks expected 1 at cycle %0d", ack_q.size(), c0 + 1);
        end
        checks++;
        if (acc_q.size() != 17) begin failures++; $display("FAIL prio_naccess: got %0d expected 17", acc_q.size()); end
        checks++;
        if (out_q.size() != 16) begin failures++; $display("FAIL prio_nword: got %0d expected 16", out_q.size()); end
        if (acc_q.size() == 17) begin
            ea = {32'(c0 + 1), 1'b1, 16'h1000, 16'hBEEF};
            checks++;
            if (acc_q[0] !== ea) begin failures++; $display("FAIL prio_write: got %h expected %h", acc_q[0], ea); end
            for (int k = 0; k < 8; k++) begin
                ea = {32'(c0 + 3 + k), 1'b0, 16'(16'h2000 + 2 * k), 16'h0};
                checks++;
                if (acc_q[1+k] !== ea) begin failures++; $display("FAIL prio_daddr%0d: got %h expected %h", k, acc_q[1+k], ea); end
                ea = {32'(c0 + 17 + k), 1'b0, 16'(16'h0010 + 2 * k), 16'h0};
                checks++;
                if (acc_q[9+k] !== ea) begin failures++; $display("FAIL prio_iaddr%0d: got %h expected %h", k, acc_q[9+k], ea); end
            end
        end
        if (out_q.size() == 16) begin
            for (int k = 0; k < 8; k++) begin
                eo = {32'(c0 + 8 + k), 1'b0, 1'b1, 1'b0, k == 7, 3'(k), 16'(16'h2000 + 2 * k) ^ 16'hA5A5};
                checks++;
                if (out_q[k] !== eo) begin failures++; $display("FAIL prio_dword%0d: got %h expected %h", k, out_q[k], eo); end
                eo = {32'(c0 + 22 + k), 1'b1, 1'b0, k == 7, 1'b0, 3'(k), 16'(16'h0010 + 2 * k) ^ 16'hA5A5};
                checks++;
                if (out_q[8+k] !== eo) begin failures++; $display("FAIL prio_iword%0d: got %h expected %h", k, out_q[8+k], eo); end
            end
        end
    endtask

    task automatic test_wrap();
        bit ok; int zeros;
        acc_q.delete(); out_q.delete();
        bus.d_fill_addr = 16'hFFFA; bus.d_fill_req = 1;
        wait_done(0, 40, ok);
        bus.d_fill_req = 0;
        checks++;
        if (!ok) begin failures++; $display("FAIL wrap_done: got timeout expected pulse"); end
        tick(2);
        checks++;
        if (acc_q.size() != 8) begin failures++; $display("FAIL wrap_naddr: got %0d expected 8", acc_q.size()); end
        zeros = 0;
        foreach (acc_q[k]) if (acc_q[k].a == 16'h0000) zeros++;
        checks++;
        if (zeros != 0) begin failures++; $display("FAIL wrap_zero_access: got %0d expected 0", zeros); end
        for (int k = 0; k < 8 && k < acc_q.size(); k++) begin
            checks++;
            if (acc_q[k].a !== 16'(16'hFFF0 + 2 * k)) begin
                failures++; $display("FAIL wrap_addr%0d: got %h expected %h", k, acc_q[k].a, 16'(16'hFFF0 + 2 * k));
            end
        end
        for (int k = 0; k < 8 && k < out_q.size(); k++) begin
            checks++;
            if (out_q[k].d !== (16'(16'hFFF0 + 2 * k) ^ 16'hA5A5) || out_q[k].dv !== 1'b1) begin
                failures++; $display("FAIL wrap_word%0d: got %h expected %h", k, out_q[k].d, 16'(16'hFFF0 + 2 * k) ^ 16'hA5A5);
            end
        end
    endtask

    task automatic test_reset_mid();
        int late0, c0; bit ok;
        acc_q.delete(); out_q.delete();
        bus.i_fill_addr = 16'h0100; bus.i_fill_req = 1;
        for (int k = 0; k < 20 && acc_q.size() < 3; k++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (acc_q.size() != 3) begin failures++; $display("FAIL rstmid_issued: got %0d expected 3", acc_q.size()); end
        rst_n = 0; bus.i_fill_req = 0;
        tick(1);
        rst_n = 1;
        checks++;
        if (bus.busy !== 1'b0 || bus.mem_enable !== 1'b0) begin
            failures++; $display("FAIL rstmid_idle: got busy=%b en=%b expected 0 0", bus.busy, bus.mem_enable);
        end
        late0 = late_v;
        tick(8);
        checks++;
        if (out_q.size() != 0) begin failures++; $display("FAIL rstmid_late_words: got %0d expected 0", out_q.size()); end
        checks++;
        if (late_v - late0 != 3) begin failures++; $display("FAIL rstmid_late_pulses: got %0d expected 3", late_v - late0); end
        acc_q.delete(); out_q.delete();
        c0 = cyc;
        bus.i_fill_addr = 16'h0200; bus.i_fill_req = 1;
        wait_done(1, 40, ok);
        bus.i_fill_req = 0;
        tick(2);
        checks++;
        if (!ok || out_q.size() != 8) begin failures++; $display("FAIL rstmid_refill: got %0d words expected 8", out_q.size()); end
        for (int k = 0; k < 8 && k < out_q.size(); k++) begin
            checks++;
            if (out_q[k].idx !== 3'(k) || out_q[k].d !== (16'(16'h0200 + 2 * k) ^ 16'hA5A5) || out_q[k].c != c0 + 6 + k) begin
                failures++; $display("FAIL rstmid_word%0d: got %h expected idx %0d data %h", k, out_q[k], k, 16'(16'h0200 + 2 * k) ^ 16'hA5A5);
            end
        end
    endtask

    task automatic test_drop();
        bit ok;
        acc_q.delete(); out_q.delete();
        bus.i_fill_addr = 16'h0304; bus.i_fill_req = 1;
        tick(1);
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL drop_granted: got busy=%b expected 1", bus.busy); end
        bus.i_fill_req = 0;
        wait_done(1, 40, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL drop_done: got timeout expected pulse"); end
        tick(2);
        checks++;
        if (out_q.size() != 8) begin failures++; $display("FAIL drop_nword: got %0d expected 8", out_q.size()); end
        for (int k = 0; k < 8 && k < out_q.size(); k++) begin
            checks++;
            if (out_q[k].idx !== 3'(k) || out_q[k].id !== (k == 7) || out_q[k].d !== (16'(16'h0300 + 2 * k) ^ 16'hA5A5)) begin
                failures++; $display("FAIL drop_word%0d: got %h expected idx %0d data %h", k, out_q[k], k, 16'(16'h0300 + 2 * k) ^ 16'hA5A5);
            end
        end
    endtask

    task automatic test_protocol();
        bit ok;
        out_q.delete();
        inj = 1;
        tick(2);
        inj = 0;
        tick(1);
        checks++;
        if (out_q.size() != 0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL proto_idle_valid: got %0d words busy=%b expected 0 0", out_q.size(), bus.busy);
        end
        bus.i_fill_addr = 16'h0400; bus.i_fill_req = 1;
        tick(1);
        inj = 1;
        @(posedge clk);
        #1 inj = 0;
        wait_done(1, 40, ok);
        bus.i_fill_req = 0;
        tick(2);
        checks++;
        if (!ok || out_q.size() != 8) begin failures++; $display("FAIL proto_nword: got %0d expected 8", out_q.size()); end
        for (int k = 0; k < 8 && k < out_q.size(); k++) begin
            checks++;
            if (out_q[k].idx !== 3'(k) || out_q[k].d !== (16'(16'h0400 + 2 * k) ^ 16'hA5A5)) begin
                failures++; $display("FAIL proto_word%0d: got %h expected idx %0d data %h", k, out_q[k], k, 16'(16'h0400 + 2 * k) ^ 16'hA5A5);
            end
        end
    endtask

    task automatic test_idle_outputs();
        checks++;
        if (bad_idle != 0) begin failures++; $display("FAIL idle_zero_outputs: got %0d nonzero cycles expected 0", bad_idle); end
    endtask

    initial begin
        test_reset();
        test_i_fill();
        test_priority();
        test_wrap();
        test_reset_mid();
        test_drop();
        test_protocol();
        test_idle_outputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
